// File: rtl/fpnew_slice_result_receiver_pkg.sv
// Shared types and sizing helpers for the slice result receiver.
// Optional sticky flag accumulation is enabled with FPNEW_RECV_STICKY_FLAGS_EN.
package fpnew_slice_result_receiver_pkg;

    // Same layout as the FPU status flags: NV DZ OF UF NX, MSB first.
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    // Pointer width for a Depth-entry FIFO; at least one bit so Depth=1 still builds.
    function automatic int unsigned recv_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Number of low result bits covered by expanded CMP lanes, clamped to the datapath.
    function automatic int unsigned cmp_lane_bits(input int unsigned width,
                                                  input int unsigned fp_width,
                                                  input int unsigned lanes);
        return (fp_width * lanes > width) ? width : fp_width * lanes;
    endfunction

endpackage

// File: rtl/fpnew_slice_result_receiver_if.sv
// Slice-side and writeback-side handshake bundle of the slice result receiver.
// slave = the receiver, master = the slice/writeback environment.
interface fpnew_slice_result_receiver_if
    import fpnew_slice_result_receiver_pkg::*;
#(
    parameter int unsigned Width   = 64,
    parameter type         TagType = logic
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [Width-1:0] result_i;
    status_t          status_i;
    logic             extension_bit_i;
    TagType           tag_i;
    logic             is_cmp_i;
    logic             vectorial_i;

    logic             out_valid_o;
    logic             out_ready_i;
    logic [Width-1:0] result_o;
    status_t          status_o;
    logic             extension_bit_o;
    TagType           tag_o;

    modport slave (
        input  in_valid_i, result_i, status_i, extension_bit_i, tag_i, is_cmp_i, vectorial_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o, result_o, status_o, extension_bit_o, tag_o
    );

    modport master (
        output in_valid_i, result_i, status_i, extension_bit_i, tag_i, is_cmp_i, vectorial_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o, result_o, status_o, extension_bit_o, tag_o
    );

endinterface

// File: rtl/fpnew_recv_fifo.sv
// Generic synchronous-reset FIFO with flush and occupancy; a full FIFO accepts
// a push in the same cycle as a pop. No bypass: data appears one cycle after push.
module fpnew_recv_fifo
    import fpnew_slice_result_receiver_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Depth     = 2,
    localparam int unsigned PtrW     = recv_ptr_w(Depth),
    localparam int unsigned CntW     = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 push_valid_i,
    output logic                 push_ready_o,
    input  logic [DataWidth-1:0] data_i,
    output logic                 pop_valid_o,
    input  logic                 pop_ready_i,
    output logic [DataWidth-1:0] data_o,
    output logic [CntW-1:0]      occupancy_o
);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic [CntW-1:0]      count;
    logic                 push, pop;

    // Explicit wrap keeps the pointers modulo Depth even when Depth is 1.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign pop_valid_o  = (count != '0);
    assign pop          = pop_valid_o && pop_ready_i;
    assign push_ready_o = (count != FullCnt) || pop;
    assign push         = push_valid_i && push_ready_o && !flush_i;
    assign data_o       = mem[rd_ptr];
    assign occupancy_o  = count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the occupancy count alone decides
    // validity, so stale payload is never observed and the array stays plain RAM.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/fpnew_slice_result_receiver.sv
// Receives slice results into a FIFO, re-expands compressed CMP bitmasks and
// presents them to writeback. FPNEW_RECV_STICKY_FLAGS_EN adds sticky fflags.
module fpnew_slice_result_receiver
    import fpnew_slice_result_receiver_pkg::*;
#(
    parameter int unsigned Width    = 64,
    parameter int unsigned FpWidth  = 32,
    parameter int unsigned NumLanes = 2,
    parameter int unsigned Depth    = 2,
    parameter type         TagType  = logic
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    flush_i,
    input  logic    fflags_clr_i,
    output logic    busy_o,
    output status_t fflags_o,
    fpnew_slice_result_receiver_if.slave bus
);
    localparam int unsigned LaneBits = cmp_lane_bits(Width, FpWidth, NumLanes);
    localparam int unsigned CntW     = $clog2(Depth + 1);

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext_bit;
        TagType           tag;
        logic             is_cmp;
        logic             vectorial;
    } entry_t;

    localparam int unsigned EntryW = $bits(entry_t);

    entry_t           wr_entry, head;
    logic [EntryW-1:0] head_bits;
    logic [CntW-1:0]  occupancy;
    logic             pop;
    logic [Width-1:0] result_exp;

    assign wr_entry = '{
        result:    bus.result_i,
        status:    bus.status_i,
        ext_bit:   bus.extension_bit_i,
        tag:       bus.tag_i,
        is_cmp:    bus.is_cmp_i,
        vectorial: bus.vectorial_i
    };

    fpnew_recv_fifo #(
        .DataWidth (EntryW),
        .Depth     (Depth)
    ) i_fifo (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .push_valid_i (bus.in_valid_i),
        .push_ready_o (bus.in_ready_o),
        .data_i       (wr_entry),
        .pop_valid_o  (bus.out_valid_o),
        .pop_ready_i  (bus.out_ready_i),
        .data_o       (head_bits),
        .occupancy_o  (occupancy)
    );

    assign head   = entry_t'(head_bits);
    assign pop    = bus.out_valid_o && bus.out_ready_i;
    assign busy_o = (occupancy != '0);

    // Inverse of slice-side compression: bit i of the mask returns to the LSB of lane i.
    // NOTE: default assignment first so every path drives result_exp and no latch is inferred.
    always_comb begin
        result_exp = head.result;
        if (head.is_cmp) begin
            result_exp = '0;
            if (head.vectorial) begin
                for (int unsigned b = LaneBits; b < Width; b++) result_exp[b] = head.ext_bit;
                for (int unsigned i = 0; i < NumLanes; i++) result_exp[i*FpWidth] = head.result[i];
            end else begin
                result_exp[0] = head.result[0];
            end
        end
    end

    assign bus.result_o        = result_exp;
    assign bus.status_o        = head.status;
    assign bus.extension_bit_o = head.ext_bit;
    assign bus.tag_o           = head.tag;

`ifdef FPNEW_RECV_STICKY_FLAGS_EN
    status_t fflags_q;

    // A clear coinciding with a pop keeps only the popped flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            fflags_q <= '0;
        end else if (fflags_clr_i) begin
            fflags_q <= pop ? head.status : '0;
        end else if (pop) begin
            fflags_q <= status_t'(fflags_q | head.status);
        end
    end

    assign fflags_o = fflags_q;
`else
    logic unused_sticky;
    assign unused_sticky = fflags_clr_i ^ pop;
    assign fflags_o      = '0;
`endif

endmodule
